// File: rtl/sram_access_arbiter_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM access arbiter.
//   arb_state_e  - arbiter FSM states
//   ACC_CNT_W    - width of the access-time down-counter (ACCESS_CYCLES <= 15)
//   sram_req_t   - latched request bundle (address + write data)
//   sat_inc16    - saturating 16-bit increment for the optional statistics
package sram_arb_pkg;

  localparam int unsigned ACC_CNT_W   = 4;
  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_WR = 2'd1,
    ACC_RD = 2'd2,
    TURN   = 2'd3
  } arb_state_e;

  // Request payload; the module parameters must not exceed these widths.
  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] data;
  } sram_req_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: requester-side handshake bundle.
//   wr_req/wr_addr/wr_data -> write request (level, held until wr_ack)
//   rd_req/rd_addr         -> read request (level, held until rd_ack)
//   wr_ack/rd_ack          <- one-cycle completion pulses
//   rd_data                <- last read word
// master = requester side, slave = arbiter side.
interface sram_access_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_W,
  parameter int unsigned DATA_W = SRAM_DATA_W
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ack, rd_ack, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ack, rd_ack, rd_data
  );

endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one external async SRAM between a write
// requester and a read requester with round-robin arbitration and a fixed
// access time of ACCESS_CYCLES cycles followed by one turnaround cycle.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   bus (slave)           wr/rd req, addr, wr data, acks, rd data
//   o_SRAM_ADDR           SRAM address
//   o_dq_out / o_dq_oe    DQ drive value and output enable, i_dq_in DQ pins
//   o_SRAM_*_N            active-low strobes (LB/UB tied low)
//   o_busy                high whenever the FSM is not idle
// Optional build macro SRAM_ARB_STATS_EN adds o_wr_cnt, o_rd_cnt and
// o_conflict_cnt (saturating 16-bit counters).
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sram_access_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]    o_SRAM_ADDR,
  output logic [DATA_W-1:0]    o_dq_out,
  output logic                 o_dq_oe,
  input  logic [DATA_W-1:0]    i_dq_in,
  output logic                 o_SRAM_WE_N,
  output logic                 o_SRAM_CE_N,
  output logic                 o_SRAM_OE_N,
  output logic                 o_SRAM_LB_N,
  output logic                 o_SRAM_UB_N,
  output logic                 o_busy
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]          o_wr_cnt,
  output logic [15:0]          o_rd_cnt,
  output logic [15:0]          o_conflict_cnt
`endif
);

  arb_state_e           r_state;
  logic [ACC_CNT_W-1:0] r_cnt;
  logic                 r_prefer_rd;
  logic                 r_wr_ack;
  logic                 r_rd_ack;
  logic [DATA_W-1:0]    r_rd_data;
  logic [ADDR_W-1:0]    r_sram_addr;
  logic [DATA_W-1:0]    r_dq_out;
  logic                 r_dq_oe;
  logic                 r_we_n;
  logic                 r_ce_n;
  logic                 r_oe_n;
  logic                 r_busy;

  logic                 w_grant_wr;
  logic                 w_grant_rd;
  sram_req_t            w_req;

  // Round-robin grant decision, only acted on in IDLE.
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (bus.wr_req && (!bus.rd_req || !r_prefer_rd)) begin
      w_grant_wr = 1'b1;
    end else if (bus.rd_req) begin
      w_grant_rd = 1'b1;
    end
    w_req.addr = w_grant_wr ? SRAM_ADDR_W'(bus.wr_addr) : SRAM_ADDR_W'(bus.rd_addr);
    w_req.data = SRAM_DATA_W'(bus.wr_data);
  end

  // Access sequencer; strobes and acks are registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_prefer_rd <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_rd_data   <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_wr_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_wr || w_grant_rd) begin
            r_sram_addr <= ADDR_W'(w_req.addr);
            r_cnt       <= ACC_CNT_W'(ACCESS_CYCLES - 1);
            r_ce_n      <= 1'b0;
            r_busy      <= 1'b1;
            // Favour the side that was not just served.
            r_prefer_rd <= w_grant_wr;
            if (w_grant_wr) begin
              r_state  <= ACC_WR;
              r_dq_out <= DATA_W'(w_req.data);
              r_we_n   <= 1'b0;
              r_dq_oe  <= 1'b1;
            end else begin
              r_state  <= ACC_RD;
              r_oe_n   <= 1'b0;
            end
          end
        end
        ACC_WR, ACC_RD: begin
          if (r_cnt == '0) begin
            r_state <= TURN;
            r_ce_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            if (r_state == ACC_WR) begin
              r_wr_ack  <= 1'b1;
            end else begin
              r_rd_ack  <= 1'b1;
              r_rd_data <= i_dq_in;
            end
          end else begin
            r_cnt <= r_cnt - ACC_CNT_W'(1);
          end
        end
        TURN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ack  = r_wr_ack;
  assign bus.rd_ack  = r_rd_ack;
  assign bus.rd_data = r_rd_data;
  assign o_SRAM_ADDR = r_sram_addr;
  assign o_dq_out    = r_dq_out;
  assign o_dq_oe     = r_dq_oe;
  assign o_SRAM_WE_N = r_we_n;
  assign o_SRAM_CE_N = r_ce_n;
  assign o_SRAM_OE_N = r_oe_n;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;
  assign o_busy      = r_busy;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;
  logic [15:0] r_conflict_cnt;

  // Completion counts advance on the edge that raises the matching ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (r_state == ACC_WR && r_cnt == '0) r_wr_cnt <= sat_inc16(r_wr_cnt);
      if (r_state == ACC_RD && r_cnt == '0) r_rd_cnt <= sat_inc16(r_rd_cnt);
      if (r_state == IDLE && bus.wr_req && bus.rd_req) begin
        r_conflict_cnt <= sat_inc16(r_conflict_cnt);
      end
    end
  end

  assign o_wr_cnt       = r_wr_cnt;
  assign o_rd_cnt       = r_rd_cnt;
  assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the single 16-bit external SRAM between two requesters: the recorder write path and the DSP playback read path.
- Each requester uses a req/ack handshake. The block sequences every SRAM access with a fixed access time and arbitrates round-robin when both requesters ask at once.
- It replaces the top-level's state-based mux of SRAM address, data and write-enable, so recording and playback can overlap safely. Sits between AudRecorder / AudDSP and the SRAM pins.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, cycles the SRAM strobes are held per access; legal range 1..15.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_wr_req  input  1  write request; level, held until o_wr_ack
- i_wr_addr  input  ADDR_W  write address; stable while i_wr_req is high
- i_wr_data  input  DATA_W  write data; stable while i_wr_req is high
- o_wr_ack  output  1  one-cycle pulse: write completed
- i_rd_req  input  1  read request; level, held until o_rd_ack
- i_rd_addr  input  ADDR_W  read address; stable while i_rd_req is high
- o_rd_ack  output  1  one-cycle pulse: read completed, o_rd_data valid
- o_rd_data  output  DATA_W  last read word; held until the next read completes
- o_SRAM_ADDR  output  ADDR_W  SRAM address
- o_dq_out  output  DATA_W  data to be driven onto the DQ pins
- o_dq_oe  output  1  DQ output enable; top-level builds the tristate from it
- i_dq_in  input  DATA_W  DQ pin value
- o_SRAM_WE_N / o_SRAM_CE_N / o_SRAM_OE_N  output  1 each  active-low SRAM strobes
- o_SRAM_LB_N / o_SRAM_UB_N  output  1 each  constant 0 (full-word access only)
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking: one clock (i_clk); synchronous active-low reset (i_rst_n). All outputs are registered.
- Reset values: state = IDLE; acks = 0; o_rd_data = 0; o_SRAM_ADDR = 0; o_dq_out = 0; o_dq_oe = 0; WE_N = CE_N = OE_N = 1; o_busy = 0; round-robin pointer = "write preferred".
- Reset asserted mid-access aborts the access. Strobes return to inactive on the first clock edge with reset low. No ack is issued for the aborted access.
- FSM states: IDLE, ACC_WR, ACC_RD, TURN.
- IDLE:
  - Sample the requests. Only write pending → ACC_WR. Only read pending → ACC_RD.
  - Both pending → grant the side the pointer favours, then flip the pointer to the other side.
  - A single-requester grant also sets the pointer to favour the other side.
  - On grant, latch the address (and the data for writes) and load the counter with ACCESS_CYCLES-1.
- ACC_WR (ACCESS_CYCLES cycles): CE_N = 0, WE_N = 0, OE_N = 1, o_dq_oe = 1, address and data from the latch.
- ACC_RD (ACCESS_CYCLES cycles): CE_N = 0, OE_N = 0, WE_N = 1, o_dq_oe = 0.
  - When the counter reaches 0, capture i_dq_in into the read holding register.
- Counter: 4 bits, decrements each access cycle. At 0 → TURN.
- TURN (exactly 1 cycle):
  - All strobes inactive; o_dq_oe = 0 (bus turnaround).
  - Pulse the ack of the completed side for 1 cycle. For a read, o_rd_data is updated in the same cycle as o_rd_ack.
  - Then → IDLE.
- Requester rule: drop or renew the request in the cycle after the ack. A request seen in IDLE is always treated as new.
- Throughput: grant-to-ack latency = ACCESS_CYCLES + 1 cycles; each access occupies ACCESS_CYCLES + 2 cycles including IDLE.
- Request dropped mid-access: the access still completes and the ack still pulses; the requester ignores it.
- Address/data changes while granted are ignored because the values are latched.
- Never more than one ack high in a cycle. WE_N and OE_N are never low together.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs o_wr_cnt [15:0], o_rd_cnt [15:0] and o_conflict_cnt [15:0].
  - Increments: o_wr_cnt / o_rd_cnt on each o_wr_ack / o_rd_ack; o_conflict_cnt on each IDLE cycle where both requests are high.
  - All three saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package sram_arb_pkg holds:
  - the state enum (IDLE, ACC_WR, ACC_RD, TURN);
  - constant ACC_CNT_W = 4;
  - a typedef for the request bundle (addr, data).
- No sub-module. The optional saturating counters may use a small sat_counter16 instance.

Test Plan (ACCESS_CYCLES = 2 unless stated):
- Reset, then write only: wr_req with addr 0x00010, data 0xA5A5 → WE_N low in cycles 2–3 after req, o_dq_out = 0xA5A5, o_wr_ack in cycle 4, o_busy falls after TURN.
- Read only: SRAM model returns 0x1234 at 0x00020 → o_rd_ack with o_rd_data = 0x1234 exactly 3 cycles after grant; o_dq_oe stays 0 throughout.
- Both requests simultaneously after reset: write granted first, then read. Keep both asserted → grants alternate W, R, W, R; conflict count = 4 after 4 accesses (with SRAM_ARB_STATS_EN).
- Back-to-back reads held for 10 accesses → one ack every 4 cycles, addresses 0..9 appear in order.
- Assert i_rst_n = 0 during ACC_WR → strobes high on the next edge, no o_wr_ack, FSM in IDLE after release.
- ACCESS_CYCLES = 1 and = 15 → access strobe widths of 1 and 15 cycles. Assertions throughout: never WE_N & OE_N both low, never two acks in the same cycle.
